// File: rtl/imem_fetch_unit.sv
// Instruction-fetch front end: drives the sync-read instruction memory from next_pc and pairs each word with its PC.
// Optional IFU_PERF_CNT_EN builds accepted-instruction and stalled-cycle counters.
module imem_fetch_unit #(
   parameter int          ADDR_WIDTH = 16,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   output logic [ADDR_WIDTH-1:0] o_imem_addr,
   output logic                  o_imem_wren,
   output logic [3:0]            o_imem_bmask,
   output logic [31:0]           o_imem_wdata,
   input  logic [31:0]           i_imem_rdata,
   input  logic                  i_stall,
   input  logic                  i_redirect,
   input  logic [31:0]           i_redirect_pc,
   output logic                  o_valid,
   output logic [31:0]           o_pc,
   output logic [31:0]           o_instr,
   output logic                  o_fault,
   output logic [31:0]           o_fetch_cnt,
   output logic [31:0]           o_stall_cnt
);

   logic [31:0] r_rsp_pc;
   logic        r_rsp_valid;
   logic        r_rsp_fault;
   logic [31:0] w_next_pc;

   // Next fetch address; a stall re-reads the current word so the memory output stays stable.
   always_comb begin
      w_next_pc = r_rsp_pc;
      if (!i_reset) begin
         w_next_pc = RESET_PC;
      end else if (i_redirect) begin
         w_next_pc = {i_redirect_pc[31:2], 2'b00};
      end else if (!r_rsp_valid || i_stall) begin
         w_next_pc = r_rsp_pc;
      end else begin
         w_next_pc = r_rsp_pc + 32'd4;
      end
   end

   // Track the address the memory sampled at the last edge, plus its validity and fault flag.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_rsp_pc    <= RESET_PC;
         r_rsp_valid <= 1'b0;
         r_rsp_fault <= 1'b0;
      end else begin
         r_rsp_pc    <= w_next_pc;
         r_rsp_valid <= 1'b1;
         r_rsp_fault <= i_redirect & (|i_redirect_pc[1:0]);
      end
   end

   assign o_imem_addr  = w_next_pc[ADDR_WIDTH-1:0];
   assign o_imem_wren  = 1'b0;
   assign o_imem_bmask = 4'b0000;
   assign o_imem_wdata = 32'h0000_0000;

   // A redirect kills the slot currently presented, stalled or not.
   assign o_valid = i_reset & r_rsp_valid & ~i_redirect;
   assign o_pc    = r_rsp_pc;
   assign o_instr = i_imem_rdata;
   assign o_fault = o_valid & r_rsp_fault;

`ifdef IFU_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;
   logic        w_accept;
   logic        w_stall_valid;

   assign w_accept      = o_valid & ~i_stall;
   assign w_stall_valid = o_valid & i_stall;

   // Performance counters, free-running modulo 2^32.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_fetch_cnt <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if (w_accept) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end else begin
            r_fetch_cnt <= r_fetch_cnt;
         end
         if (w_stall_valid) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end else begin
            r_stall_cnt <= r_stall_cnt;
         end
      end
   end

   assign o_fetch_cnt = r_fetch_cnt;
   assign o_stall_cnt = r_stall_cnt;
`else
   assign o_fetch_cnt = 32'd0;
   assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit with a behavioural sync-read memory and an expected-instruction queue.
module tb_imem_fetch_unit;

   localparam int AW = 16;
`ifdef IFU_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc;
      logic        efault;
      logic [15:0] eaddr;
   } cyc_t;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic [AW-1:0] o_imem_addr;
   logic          o_imem_wren;
   logic [3:0]    o_imem_bmask;
   logic [31:0]   o_imem_wdata;
   logic [31:0]   i_imem_rdata;
   logic          i_stall;
   logic          i_redirect;
   logic [31:0]   i_redirect_pc;
   logic          o_valid;
   logic [31:0]   o_pc;
   logic [31:0]   o_instr;
   logic          o_fault;
   logic [31:0]   o_fetch_cnt;
   logic [31:0]   o_stall_cnt;

   logic [31:0] mem [0:16383];
   exp_t        exp_q [$];
   exp_t        e;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 i_clk = ~i_clk;

   // Synchronous-read instruction memory; addresses alias modulo its size.
   always @(posedge i_clk) begin
      i_imem_rdata <= mem[o_imem_addr[15:2]];
   end

   imem_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(32'h0000_0000)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .o_imem_addr(o_imem_addr), .o_imem_wren(o_imem_wren),
      .o_imem_bmask(o_imem_bmask), .o_imem_wdata(o_imem_wdata),
      .i_imem_rdata(i_imem_rdata), .i_stall(i_stall),
      .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
      .o_valid(o_valid), .o_pc(o_pc), .o_instr(o_instr), .o_fault(o_fault),
      .o_fetch_cnt(o_fetch_cnt), .o_stall_cnt(o_stall_cnt)
   );

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         @(posedge i_clk); #1;
         @(negedge i_clk);
         n_vec++;
         if ({o_valid, o_fault, o_imem_wren, o_imem_bmask, o_imem_wdata, o_imem_addr} !== {1'b0, 1'b0, 1'b0, 4'b0000, 32'd0, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_out c%0d: got valid=%b fault=%b wren=%b bmask=%b wdata=%h addr=%h, want all 0", c, o_valid, o_fault, o_imem_wren, o_imem_bmask, o_imem_wdata, o_imem_addr);
         end
         n_vec++;
         if ({o_fetch_cnt, o_stall_cnt} !== {32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_cnt c%0d: got %0d/%0d want 0/0", c, o_fetch_cnt, o_stall_cnt);
         end
      end
      @(posedge i_clk); #1;
      i_reset = 1'b1;
      @(negedge i_clk);
      n_vec++;
      if ({o_valid, o_imem_addr} !== {1'b0, 16'h0000}) begin
         n_err++;
         $display("FAIL release_first: got valid=%b addr=%h want 0/0000", o_valid, o_imem_addr);
      end
      @(posedge i_clk); #1;
   endtask

   task automatic test_stall();
      cyc_t t [5];
      t = '{
         '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 16'h0004},
         '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 16'h0004},
         '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 16'h0004},
         '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 16'h0004},
         '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 16'h0008}
      };
      for (int c = 0; c < 5; c++) begin
         i_reset = t[c].rst; i_stall = t[c].stall; i_redirect = t[c].redir; i_redirect_pc = t[c].rpc;
         if (t[c].ev) exp_q.push_back('{t[c].epc, mem[t[c].epc[15:2]], t[c].efault});
         @(negedge i_clk);
         n_vec++;
         if ({o_valid, o_imem_addr} !== {t[c].ev, t[c].eaddr}) begin
            n_err++;
            $display("FAIL stall_ctl c%0d: got valid=%b addr=%h want %b/%h", c, o_valid, o_imem_addr, t[c].ev, t[c].eaddr);
         end
         if (t[c].ev) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({o_pc, o_instr, o_fault} !== {e.pc, e.instr, e.fault}) begin
               n_err++;
               $display("FAIL stall_insn c%0d: got pc=%h instr=%h fault=%b want %h/%h/%b", c, o_pc, o_instr, o_fault, e.pc, e.instr, e.fault);
            end
         end
         @(posedge i_clk); #1;
      end
      n_vec++;
      if ({o_fetch_cnt, o_stall_cnt} !== (PERF ? {32'd2, 32'd3} : {32'd0, 32'd0})) begin
         n_err++;
         $display("FAIL stall_cnt: got fetch=%0d stall=%0d want %0d/%0d", o_fetch_cnt, o_stall_cnt, PERF ? 2 : 0, PERF ? 3 : 0);
      end
   endtask

   task automatic test_redirect();
      cyc_t t [6];
      t = '{
         '{1'b1, 1'b0, 1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 16'h0040},
         '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  1'b0, 16'h0044},
         '{1'b1, 1'b1, 1'b1, 32'h102, 1'b0, 32'h0,   1'b0, 16'h0100},
         '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 16'h0104},
         '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 16'h0108},
         '{1'b1, 1'b0, 1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 16'h0040}
      };
      for (int c = 0; c < 6; c++) begin
         i_reset = t[c].rst; i_stall = t[c].stall; i_redirect = t[c].redir; i_redirect_pc = t[c].rpc;
         if (t[c].ev) exp_q.push_back('{t[c].epc, mem[t[c].epc[15:2]], t[c].efault});
         @(negedge i_clk);
         n_vec++;
         if ({o_valid, o_fault, o_imem_addr} !== {t[c].ev, t[c].ev & t[c].efault, t[c].eaddr}) begin
            n_err++;
            $display("FAIL redirect_ctl c%0d: got valid=%b fault=%b addr=%h want %b/%b/%h", c, o_valid, o_fault, o_imem_addr, t[c].ev, t[c].ev & t[c].efault, t[c].eaddr);
         end
         if (t[c].ev) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({o_pc, o_instr, o_fault} !== {e.pc, e.instr, e.fault}) begin
               n_err++;
               $display("FAIL redirect_insn c%0d: got pc=%h instr=%h fault=%b want %h/%h/%b", c, o_pc, o_instr, o_fault, e.pc, e.instr, e.fault);
            end
         end
         @(posedge i_clk); #1;
      end
      n_vec++;
      if ({o_fetch_cnt, o_stall_cnt} !== (PERF ? {32'd5, 32'd3} : {32'd0, 32'd0})) begin
         n_err++;
         $display("FAIL redirect_cnt: got fetch=%0d stall=%0d want %0d/%0d", o_fetch_cnt, o_stall_cnt, PERF ? 5 : 0, PERF ? 3 : 0);
      end
   endtask

   task automatic test_reset_mid();
      cyc_t t [7];
      t = '{
         '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 16'h0000},
         '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 16'h0000},
         '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 16'h0000},
         '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 16'h0004},
         '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 16'h0008},
         '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 16'h000C},
         '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC, 1'b0, 16'h0010}
      };
      for (int c = 0; c < 7; c++) begin
         i_reset = t[c].rst; i_stall = t[c].stall; i_redirect = t[c].redir; i_redirect_pc = t[c].rpc;
         if (t[c].ev) exp_q.push_back('{t[c].epc, mem[t[c].epc[15:2]], t[c].efault});
         @(negedge i_clk);
         n_vec++;
         if ({o_valid, o_fault, o_imem_addr} !== {t[c].ev, 1'b0, t[c].eaddr}) begin
            n_err++;
            $display("FAIL rstmid_ctl c%0d: got valid=%b fault=%b addr=%h want %b/0/%h", c, o_valid, o_fault, o_imem_addr, t[c].ev, t[c].eaddr);
         end
         if (t[c].ev) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({o_pc, o_instr, o_fault} !== {e.pc, e.instr, e.fault}) begin
               n_err++;
               $display("FAIL rstmid_insn c%0d: got pc=%h instr=%h fault=%b want %h/%h/%b", c, o_pc, o_instr, o_fault, e.pc, e.instr, e.fault);
            end
         end
         @(posedge i_clk); #1;
      end
      n_vec++;
      if ({o_fetch_cnt, o_stall_cnt} !== (PERF ? {32'd4, 32'd0} : {32'd0, 32'd0})) begin
         n_err++;
         $display("FAIL rstmid_cnt: got fetch=%0d stall=%0d want %0d/0", o_fetch_cnt, o_stall_cnt, PERF ? 4 : 0);
      end
   endtask

   task automatic test_wrap();
      cyc_t t [4];
      t = '{
         '{1'b1, 1'b0, 1'b1, 32'hFFFC, 1'b0, 32'h0,       1'b0, 16'hFFFC},
         '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'hFFFC,    1'b0, 16'h0000},
         '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h1_0000,  1'b0, 16'h0004},
         '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h1_0004,  1'b0, 16'h0008}
      };
      for (int c = 0; c < 4; c++) begin
         i_reset = t[c].rst; i_stall = t[c].stall; i_redirect = t[c].redir; i_redirect_pc = t[c].rpc;
         if (t[c].ev) exp_q.push_back('{t[c].epc, mem[t[c].epc[15:2]], t[c].efault});
         @(negedge i_clk);
         n_vec++;
         if ({o_valid, o_imem_addr} !== {t[c].ev, t[c].eaddr}) begin
            n_err++;
            $display("FAIL wrap_ctl c%0d: got valid=%b addr=%h want %b/%h", c, o_valid, o_imem_addr, t[c].ev, t[c].eaddr);
         end
         if (t[c].ev) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({o_pc, o_instr, o_fault} !== {e.pc, e.instr, e.fault}) begin
               n_err++;
               $display("FAIL wrap_insn c%0d: got pc=%h instr=%h fault=%b want %h/%h/%b", c, o_pc, o_instr, o_fault, e.pc, e.instr, e.fault);
            end
         end
         @(posedge i_clk); #1;
      end
      n_vec++;
      if ({o_fetch_cnt, o_stall_cnt} !== (PERF ? {32'd7, 32'd0} : {32'd0, 32'd0})) begin
         n_err++;
         $display("FAIL wrap_cnt: got fetch=%0d stall=%0d want %0d/0", o_fetch_cnt, o_stall_cnt, PERF ? 7 : 0);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: got %0d entries left want 0", exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'hA500_0000 + i;
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h0010_0113;
      mem[2] = 32'h0020_81B3;
      mem[3] = 32'h0000_0013;
      i_reset       = 1'b0;
      i_stall       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = 32'h0000_0000;
      test_reset();
      test_stall();
      test_redirect();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
